alu_exec_unit: RTL and testbench

- Execution end of the RS→ALU issue interface and source of the ALU result broadcast consumed by RS, LSB and RoB.
- Accepts at most one operation per cycle with no backpressure; op 0 is a bubble.
- Simple integer and branch-compare ops complete in 1 cycle.
- Optional RV32M multiplies use a fixed-latency pipeline.
- A small output buffer serialises collisions so that at most one result is broadcast per cycle.

---
 rtl/alu_exec_unit_pkg.sv | 79 +++++++
 rtl/alu_result_buf.sv | 91 +++++++++
 rtl/alu_exec_unit.sv | 184 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Op codes and datapath helpers shared by the decoder, reservation station and ALU.
// The multiply helpers are only reached when ALU_MUL_EN is defined.
package alu_exec_unit_pkg;

  localparam int ROB_ADDR_W = 4;

  localparam logic [5:0] ALU_NOP    = 6'd0;
  localparam logic [5:0] ALU_ADD    = 6'd1;
  localparam logic [5:0] ALU_SUB    = 6'd2;
  localparam logic [5:0] ALU_AND    = 6'd3;
  localparam logic [5:0] ALU_OR     = 6'd4;
  localparam logic [5:0] ALU_XOR    = 6'd5;
  localparam logic [5:0] ALU_SLL    = 6'd6;
  localparam logic [5:0] ALU_SRL    = 6'd7;
  localparam logic [5:0] ALU_SRA    = 6'd8;
  localparam logic [5:0] ALU_SLT    = 6'd9;
  localparam logic [5:0] ALU_SLTU   = 6'd10;
  localparam logic [5:0] ALU_PASS2  = 6'd11;
  localparam logic [5:0] ALU_BEQ    = 6'd12;
  localparam logic [5:0] ALU_BNE    = 6'd13;
  localparam logic [5:0] ALU_BLT    = 6'd14;
  localparam logic [5:0] ALU_BGE    = 6'd15;
  localparam logic [5:0] ALU_BLTU   = 6'd16;
  localparam logic [5:0] ALU_BGEU   = 6'd17;
  localparam logic [5:0] ALU_MUL    = 6'd18;
  localparam logic [5:0] ALU_MULH   = 6'd19;
  localparam logic [5:0] ALU_MULHSU = 6'd20;
  localparam logic [5:0] ALU_MULHU  = 6'd21;

  function automatic logic is_mul_op(input logic [5:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
  endfunction

  // Single-cycle result; anything not listed (including multiplies) yields zero.
  function automatic logic [31:0] alu_simple(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (op)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_SLL:   r = a << b[4:0];
      ALU_SRL:   r = a >> b[4:0];
      ALU_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:   r = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU:  r = {31'd0, (a < b)};
      ALU_PASS2: r = b;
      ALU_BEQ:   r = {31'd0, (a == b)};
      ALU_BNE:   r = {31'd0, (a != b)};
      ALU_BLT:   r = {31'd0, ($signed(a) < $signed(b))};
      ALU_BGE:   r = {31'd0, ($signed(a) >= $signed(b))};
      ALU_BLTU:  r = {31'd0, (a < b)};
      ALU_BGEU:  r = {31'd0, (a >= b)};
      default:   r = 32'd0;
    endcase
    return r;
  endfunction

  // Operands are sign- or zero-extended to 64 bits so one product serves all four ops.
  function automatic logic [31:0] alu_mul(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    logic [31:0] r;
    ea = {{32{a[31] & ((op == ALU_MULH) || (op == ALU_MULHSU))}}, a};
    eb = {{32{b[31] & (op == ALU_MULH)}}, b};
    p  = ea * eb;
    case (op)
      ALU_MUL: r = p[31:0];
      default: r = p[63:32];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_result_buf.sv
// Circular result buffer: up to two pushes and one pop per enabled cycle,
// synchronous clear, pointers wrapping modulo DEPTH.
module alu_result_buf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en,
  input  logic             clr,
  input  logic             push_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             push_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_s;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign pop_s = pop && (count_q != {CW{1'b0}});

  // When both push, data_a lands first so its result drains first.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (en && clr) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else if (en) begin
      if (push_a && push_b) begin
        mem_d[tail_q]           = data_a;
        mem_d[wrap_inc(tail_q)] = data_b;
        tail_d                  = wrap_inc(wrap_inc(tail_q));
      end else if (push_a) begin
        mem_d[tail_q] = data_a;
        tail_d        = wrap_inc(tail_q);
      end else if (push_b) begin
        mem_d[tail_q] = data_b;
        tail_d        = wrap_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = wrap_inc(head_q);
      end else begin
        head_d = head_q;
      end
      count_d = CW'(int'(count_q) + int'(push_a) + int'(push_b) - int'(pop_s));
    end else begin
      count_d = count_q;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[head_q];
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage with a single registered result broadcast per cycle.
// Define ALU_MUL_EN to add the fixed-latency RV32M multiply pipe and collision buffer.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int ROB_ADDR   = ROB_ADDR_W,
  parameter int MUL_STAGES = 3,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush,
  input  logic [5:0]          in_op,
  input  logic [31:0]         in_rs1,
  input  logic [31:0]         in_rs2,
  input  logic [ROB_ADDR-1:0] in_id,
  output logic                out_valid,
  output logic [ROB_ADDR-1:0] out_robid,
  output logic [31:0]         out_val
);

  if (MUL_STAGES < 1) begin : g_bad_stages
    $error("alu_exec_unit: MUL_STAGES must be at least 1");
  end
  if (OBUF_DEPTH < MUL_STAGES) begin : g_bad_depth
    $error("alu_exec_unit: OBUF_DEPTH must be at least MUL_STAGES");
  end

  logic                out_valid_q, out_valid_d;
  logic [ROB_ADDR-1:0] out_robid_q, out_robid_d;
  logic [31:0]         out_val_q, out_val_d;
  logic                simple_v_s;
  logic [31:0]         simple_val_s;
  logic                win_v_s;
  logic [ROB_ADDR-1:0] win_id_s;
  logic [31:0]         win_val_s;

  assign simple_val_s = alu_simple(in_op, in_rs1, in_rs2);

`ifdef ALU_MUL_EN
  localparam int EW = ROB_ADDR + 32;
  localparam int CW = $clog2(OBUF_DEPTH + 1);

  logic [MUL_STAGES-1:0] mul_vld_q, mul_vld_d;
  logic [ROB_ADDR-1:0]   mul_id_q  [MUL_STAGES];
  logic [ROB_ADDR-1:0]   mul_id_d  [MUL_STAGES];
  logic [31:0]           mul_val_q [MUL_STAGES];
  logic [31:0]           mul_val_d [MUL_STAGES];
  logic                  mul_out_v_s;
  logic                  buf_empty_s, buf_pop_s, push_a_s, push_b_s, buf_room_s;
  logic [CW-1:0]         buf_count_s;
  logic [EW-1:0]         buf_head_s;

  assign simple_v_s  = (in_op != ALU_NOP) && !is_mul_op(in_op);
  assign mul_out_v_s = mul_vld_q[MUL_STAGES-1];
  // Occupancy is bounded by multiplies in flight; this guard never trips in legal use.
  assign buf_room_s  = (int'(buf_count_s) - int'(buf_pop_s) + int'(push_a_s) + int'(push_b_s))
                       <= OBUF_DEPTH;

  // Arbitration: buffer head, then multiply, then simple; losers queue in that order.
  always_comb begin
    buf_pop_s = 1'b0;
    push_a_s  = 1'b0;
    push_b_s  = 1'b0;
    win_v_s   = 1'b0;
    win_id_s  = {ROB_ADDR{1'b0}};
    win_val_s = 32'd0;
    if (!buf_empty_s) begin
      buf_pop_s             = 1'b1;
      win_v_s               = 1'b1;
      {win_id_s, win_val_s} = buf_head_s;
      push_a_s              = mul_out_v_s;
      push_b_s              = simple_v_s;
    end else if (mul_out_v_s) begin
      win_v_s   = 1'b1;
      win_id_s  = mul_id_q[MUL_STAGES-1];
      win_val_s = mul_val_q[MUL_STAGES-1];
      push_b_s  = simple_v_s;
    end else if (simple_v_s) begin
      win_v_s   = 1'b1;
      win_id_s  = in_id;
      win_val_s = simple_val_s;
    end else begin
      win_v_s = 1'b0;
    end
  end

  // The product is formed on entry and then carried down the pipe.
  always_comb begin
    mul_vld_d = mul_vld_q;
    mul_id_d  = mul_id_q;
    mul_val_d = mul_val_q;
    if (rdy_in && flush) begin
      mul_vld_d = {MUL_STAGES{1'b0}};
    end else if (rdy_in) begin
      mul_vld_d[0] = is_mul_op(in_op);
      mul_id_d[0]  = in_id;
      mul_val_d[0] = alu_mul(in_op, in_rs1, in_rs2);
      for (int i = 1; i < MUL_STAGES; i++) begin
        mul_vld_d[i] = mul_vld_q[i-1];
        mul_id_d[i]  = mul_id_q[i-1];
        mul_val_d[i] = mul_val_q[i-1];
      end
    end else begin
      mul_vld_d = mul_vld_q;
    end
  end

  // Multiply pipe registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mul_vld_q <= {MUL_STAGES{1'b0}};
      for (int i = 0; i < MUL_STAGES; i++) begin
        mul_id_q[i]  <= {ROB_ADDR{1'b0}};
        mul_val_q[i] <= 32'd0;
      end
    end else begin
      mul_vld_q <= mul_vld_d;
      mul_id_q  <= mul_id_d;
      mul_val_q <= mul_val_d;
    end
  end

  alu_result_buf #(
    .DEPTH (OBUF_DEPTH),
    .WIDTH (EW)
  ) u_obuf (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (rdy_in),
    .clr    (flush),
    .push_a (push_a_s && buf_room_s),
    .data_a ({mul_id_q[MUL_STAGES-1], mul_val_q[MUL_STAGES-1]}),
    .push_b (push_b_s && buf_room_s),
    .data_b ({in_id, simple_val_s}),
    .pop    (buf_pop_s),
    .head   (buf_head_s),
    .empty  (buf_empty_s),
    .count  (buf_count_s)
  );
`else
  assign simple_v_s = (in_op != ALU_NOP);
  assign win_v_s    = simple_v_s;
  assign win_id_s   = in_id;
  assign win_val_s  = simple_val_s;
`endif

  // Broadcast update; robid/val keep their last value when nothing wins.
  always_comb begin
    out_valid_d = out_valid_q;
    out_robid_d = out_robid_q;
    out_val_d   = out_val_q;
    if (rdy_in && flush) begin
      out_valid_d = 1'b0;
    end else if (rdy_in && win_v_s) begin
      out_valid_d = 1'b1;
      out_robid_d = win_id_s;
      out_val_d   = win_val_s;
    end else if (rdy_in) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Broadcast registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_valid_q <= 1'b0;
      out_robid_q <= {ROB_ADDR{1'b0}};
      out_val_q   <= 32'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_robid_q <= out_robid_d;
      out_val_q   <= out_val_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_robid = out_robid_q;
  assign out_val   = out_val_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: a queue-based reference model checked every
// cycle, plus directed vectors with hand-computed values (multiply ones under ALU_MUL_EN).
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  localparam int RA = 4;
  localparam int MS = 3;
  localparam int OD = 4;
`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b1;
  logic          flush = 1'b0;
  logic [5:0]    op = 6'd0;
  logic [31:0]   a = 32'd0;
  logic [31:0]   b = 32'd0;
  logic [RA-1:0] id = 4'd0;
  logic          ov;
  logic [RA-1:0] orid;
  logic [31:0]   oval;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exec_unit #(.ROB_ADDR(RA), .MUL_STAGES(MS), .OBUF_DEPTH(OD)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush(flush),
    .in_op(op), .in_rs1(a), .in_rs2(b), .in_id(id),
    .out_valid(ov), .out_robid(orid), .out_val(oval)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [RA-1:0] id; logic [31:0] val; } res_t;
  typedef struct { logic [RA-1:0] id; logic [31:0] val; int rem; } fl_t;

  res_t          bufq[$];
  fl_t           inflight[$];
  logic          m_valid = 1'b0;
  logic [RA-1:0] m_id = 4'd0;
  logic [31:0]   m_val = 32'd0;
  int            m_maxq = 0;

  function automatic bit is_mul(input logic [5:0] o);
    return (o >= ALU_MUL) && (o <= ALU_MULHU);
  endfunction

  function automatic logic [31:0] ref_val(input logic [5:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    p  = 64'd0;
    case (o)
      ALU_ADD:    return 32'(ux + uy);
      ALU_SUB:    return 32'(ux - uy);
      ALU_AND:    return x & y;
      ALU_OR:     return x | y;
      ALU_XOR:    return x ^ y;
      ALU_SLL:    return 32'(ux * (64'd1 << y[4:0]));
      ALU_SRL:    return 32'(ux / (64'd1 << y[4:0]));
      ALU_SRA:    begin p = 64'(sx >>> y[4:0]); return p[31:0]; end
      ALU_SLT:    return (sx < sy) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (ux < uy) ? 32'd1 : 32'd0;
      ALU_PASS2:  return y;
      ALU_BEQ:    return (x == y) ? 32'd1 : 32'd0;
      ALU_BNE:    return (x != y) ? 32'd1 : 32'd0;
      ALU_BLT:    return (sx < sy) ? 32'd1 : 32'd0;
      ALU_BGE:    return (sx >= sy) ? 32'd1 : 32'd0;
      ALU_BLTU:   return (ux < uy) ? 32'd1 : 32'd0;
      ALU_BGEU:   return (ux >= uy) ? 32'd1 : 32'd0;
      ALU_MUL:    begin p = 64'(sx * sy); return MUL_ON ? p[31:0] : 32'd0; end
      ALU_MULH:   begin p = 64'(sx * sy); return MUL_ON ? p[63:32] : 32'd0; end
      ALU_MULHSU: begin p = 64'(sx * uy); return MUL_ON ? p[63:32] : 32'd0; end
      ALU_MULHU:  begin p = {32'd0, x} * {32'd0, y}; return MUL_ON ? p[63:32] : 32'd0; end
      default:    return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic y, input logic f, input logic [5:0] o,
                            input logic [31:0] x, input logic [31:0] yv, input logic [RA-1:0] i);
    res_t cands[$];
    fl_t  keep[$];
    if (r) begin
      bufq.delete();
      inflight.delete();
      m_valid = 1'b0;
      m_id    = 4'd0;
      m_val   = 32'd0;
    end else if (y && f) begin
      bufq.delete();
      inflight.delete();
      m_valid = 1'b0;
    end else if (y) begin
      if (bufq.size() > 0) cands.push_back(bufq.pop_front());
      foreach (inflight[k]) begin
        if (inflight[k].rem == 1) cands.push_back('{inflight[k].id, inflight[k].val});
        else keep.push_back('{inflight[k].id, inflight[k].val, inflight[k].rem - 1});
      end
      inflight = keep;
      if (MUL_ON && is_mul(o)) inflight.push_back('{i, ref_val(o, x, yv), MS});
      else if (o != ALU_NOP) cands.push_back('{i, ref_val(o, x, yv)});
      if (cands.size() == 0) begin
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
        m_id    = cands[0].id;
        m_val   = cands[0].val;
        for (int k = 1; k < cands.size(); k++) bufq.push_back(cands[k]);
      end
      if (bufq.size() > m_maxq) m_maxq = bufq.size();
    end
  endtask

  // Single compare process: advance the model on each edge, then check all outputs.
  initial begin : compare
    logic c_rst, c_rdy, c_fl;
    logic [5:0] c_op;
    logic [31:0] c_a, c_b;
    logic [RA-1:0] c_id;
    forever begin
      @(posedge clk);
      c_rst = rst; c_rdy = rdy; c_fl = flush; c_op = op; c_a = a; c_b = b; c_id = id;
      #1;
      model_step(c_rst, c_rdy, c_fl, c_op, c_a, c_b, c_id);
      chk("model_valid", ov, m_valid);
      chk("model_robid", orid, m_id);
      chk("model_val", oval, m_val);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [RA-1:0] i);
    op = o; a = x; b = y; id = i;
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic v, input logic [RA-1:0] i,
                            input logic [31:0] val);
    chk({name, "_valid"}, ov, v);
    if (v) begin
      chk({name, "_id"}, orid, i);
      chk({name, "_val"}, oval, val);
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic mul_vec(input string name, input logic [5:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [RA-1:0] i, input logic [31:0] e);
    drive(o, x, y, i);
    for (int k = 0; k < MS - 1; k++) drive(ALU_NOP, 32'd0, 32'd0, 4'd0);
    chk({name, "_early"}, ov, 1'b0);
    drive(ALU_NOP, 32'd0, 32'd0, 4'd0);
    expect_out(name, 1'b1, i, e);
  endtask
`endif

  initial begin : stim
    repeat (2) @(negedge clk);
    chk("reset_valid", ov, 1'b0);
    chk("reset_robid", orid, 4'd0);
    chk("reset_val", oval, 32'd0);
    rst = 1'b0;

    drive(ALU_ADD, 32'd7, 32'hFFFF_FFFD, 4'd5);  expect_out("add", 1'b1, 4'd5, 32'd4);
    drive(ALU_SRA, 32'h8000_0000, 32'd4, 4'd1);  expect_out("sra", 1'b1, 4'd1, 32'hF800_0000);
    drive(ALU_BLTU, 32'd1, 32'hFFFF_FFFF, 4'd2); expect_out("bltu", 1'b1, 4'd2, 32'd1);
    drive(ALU_NOP, 32'd9, 32'd9, 4'd9);
    chk("bubble_valid", ov, 1'b0);
    chk("bubble_hold_id", orid, 4'd2);
    drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 4'd3);  expect_out("slt", 1'b1, 4'd3, 32'd1);
    drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 4'd4); expect_out("sltu", 1'b1, 4'd4, 32'd0);
    drive(ALU_SUB, 32'd3, 32'd5, 4'd6);          expect_out("sub", 1'b1, 4'd6, 32'hFFFF_FFFE);
    drive(ALU_SLL, 32'd1, 32'd33, 4'd7);         expect_out("sll", 1'b1, 4'd7, 32'd2);
    drive(ALU_SRL, 32'h8000_0000, 32'd31, 4'd8); expect_out("srl", 1'b1, 4'd8, 32'd1);
    drive(ALU_BGE, 32'hFFFF_FFFF, 32'd1, 4'd9);  expect_out("bge", 1'b1, 4'd9, 32'd0);
    drive(ALU_BNE, 32'd5, 32'd6, 4'd10);         expect_out("bne", 1'b1, 4'd10, 32'd1);
    drive(ALU_PASS2, 32'd1, 32'h1234_5000, 4'd11); expect_out("pass2", 1'b1, 4'd11, 32'h1234_5000);
    drive(ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd12); expect_out("xor", 1'b1, 4'd12, 32'h0FF0_0FF0);
    drive(6'd63, 32'd1, 32'd2, 4'd13);           expect_out("unknown", 1'b1, 4'd13, 32'd0);
    drive(ALU_ADD, 32'hFFFF_FFFF, 32'd2, 4'd14); expect_out("add_wrap", 1'b1, 4'd14, 32'd1);
`ifndef ALU_MUL_EN
    drive(ALU_MUL, 32'd6, 32'd7, 4'd15);         expect_out("mul_off", 1'b1, 4'd15, 32'd0);
`endif

    // rdy low: registers and outputs hold, presented ops are ignored.
    drive(ALU_ADD, 32'd1, 32'd2, 4'd7);          expect_out("pre_stall", 1'b1, 4'd7, 32'd3);
    rdy = 1'b0;
    drive(ALU_ADD, 32'd10, 32'd10, 4'd8);        expect_out("stall1", 1'b1, 4'd7, 32'd3);
    drive(ALU_ADD, 32'd10, 32'd10, 4'd8);        expect_out("stall2", 1'b1, 4'd7, 32'd3);
    rdy = 1'b1;
    drive(ALU_NOP, 32'd0, 32'd0, 4'd0);          chk("post_stall_valid", ov, 1'b0);

    // Flush drops the op presented with it.
    flush = 1'b1;
    drive(ALU_ADD, 32'd1, 32'd1, 4'd9);
    chk("flush_valid", ov, 1'b0);
    chk("flush_hold_id", orid, 4'd7);
    flush = 1'b0;

`ifdef ALU_MUL_EN
    mul_vec("mul", ALU_MUL, 32'd6, 32'd7, 4'd2, 32'd42);
    mul_vec("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 32'hFFFF_FFFE);
    mul_vec("mulh", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 32'd0);
    mul_vec("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'hFFFF_FFFF);

    // Collision: MUL at edge 0, ADD at edge 3 -> MUL wins, ADD follows via the buffer.
    m_maxq = 0;
    drive(ALU_MUL, 32'd6, 32'd7, 4'd2);
    drive(ALU_NOP, 32'd0, 32'd0, 4'd0);
    drive(ALU_NOP, 32'd0, 32'd0, 4'd0);
    drive(ALU_ADD, 32'd1, 32'd1, 4'd3);          expect_out("coll_mul", 1'b1, 4'd2, 32'd42);
    drive(ALU_NOP, 32'd0, 32'd0, 4'd0);          expect_out("coll_add", 1'b1, 4'd3, 32'd2);
    drive(ALU_NOP, 32'd0, 32'd0, 4'd0);          chk("coll_idle", ov, 1'b0);
    chk("coll_maxq", m_maxq, 1);

    // Three MULs then three SUBs: six broadcasts back to back, buffer peaks at 3.
    begin
      logic [RA-1:0] eid [6];
      logic [31:0]   evl [6];
      eid[0] = 4'd1; evl[0] = 32'd10;  eid[1] = 4'd4; evl[1] = 32'd96;
      eid[2] = 4'd2; evl[2] = 32'd20;  eid[3] = 4'd5; evl[3] = 32'd95;
      eid[4] = 4'd3; evl[4] = 32'd30;  eid[5] = 4'd6; evl[5] = 32'd94;
      m_maxq = 0;
      for (int k = 1; k <= 3; k++) drive(ALU_MUL, 32'(k), 32'd10, 4'(k));
      for (int k = 0; k < 6; k++) begin
        if (k < 3) drive(ALU_SUB, 32'd100, 32'(k + 4), 4'(k + 4));
        else drive(ALU_NOP, 32'd0, 32'd0, 4'd0);
        expect_out($sformatf("burst%0d", k), 1'b1, eid[k], evl[k]);
      end
      drive(ALU_NOP, 32'd0, 32'd0, 4'd0);        chk("burst_idle", ov, 1'b0);
      chk("burst_maxq", m_maxq, 3);
    end

    // Flush with two multiplies in flight and one buffered result.
    drive(ALU_MUL, 32'd2, 32'd2, 4'd1);
    drive(ALU_MUL, 32'd3, 32'd3, 4'd2);
    drive(ALU_MUL, 32'd4, 32'd4, 4'd3);
    drive(ALU_ADD, 32'd5, 32'd5, 4'd4);          expect_out("prefl", 1'b1, 4'd1, 32'd4);
    flush = 1'b1;
    drive(ALU_ADD, 32'd6, 32'd6, 4'd5);          chk("fl_valid", ov, 1'b0);
    flush = 1'b0;
    for (int k = 0; k < MS + 2; k++) begin
      drive(ALU_NOP, 32'd0, 32'd0, 4'd0);
      chk("fl_quiet", ov, 1'b0);
    end

    // rdy low for two cycles mid-pipeline: the result arrives once, delayed by two.
    drive(ALU_MUL, 32'd3, 32'd3, 4'd4);
    drive(ALU_NOP, 32'd0, 32'd0, 4'd0);
    rdy = 1'b0;
    drive(ALU_ADD, 32'd5, 32'd5, 4'd7);          chk("mstall1", ov, 1'b0);
    drive(ALU_ADD, 32'd5, 32'd5, 4'd7);          chk("mstall2", ov, 1'b0);
    rdy = 1'b1;
    drive(ALU_NOP, 32'd0, 32'd0, 4'd0);          chk("mstall_early", ov, 1'b0);
    drive(ALU_NOP, 32'd0, 32'd0, 4'd0);          expect_out("mstall_res", 1'b1, 4'd4, 32'd9);
    drive(ALU_NOP, 32'd0, 32'd0, 4'd0);          chk("mstall_nodup", ov, 1'b0);
`endif

    // Asynchronous reset while an operation is in flight.
    drive(ALU_MUL, 32'd2, 32'd3, 4'd6);
    drive(ALU_ADD, 32'd8, 32'd8, 4'd7);
    op = ALU_NOP;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", ov, 1'b0);
    chk("arst_robid", orid, 4'd0);
    chk("arst_val", oval, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < MS + 2; k++) begin
      drive(ALU_NOP, 32'd0, 32'd0, 4'd0);
      chk("arst_quiet", ov, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
